cluster_acc_update: RTL and testbench
=====================================

# cluster_acc_update

Downstream accumulation stage for the no-division k-means datapath. It takes each point together with the index of the winning cluster chosen by the nearest-centre search, and adds the point into that cluster's per-axis accumulators. It also increments the cluster's member counter. Records are kept in the packed `{counter, accZ, accY, accX}` format consumed by the cluster compare elements, so the next iteration's tree nodes are loaded directly from `rd_data`.

## Interface
Parameters:
- `dim`, 3: point dimensionality. Only 3 is supported.
- `data_range`, 255: maximum coordinate value.
- `k`, 4: number of clusters (records held).
- `max_n`, 100: maximum members per cluster.
- Derived:
  - `dim_size = $clog2(data_range)`
  - `center_size = dim*dim_size`
  - `counter_size = $clog2(max_n)`
  - `acc_size = $clog2(dim_size*max_n)`
  - `data_size = center_size + counter_size + 3*acc_size`
  - `idx_size = max(1, $clog2(k))`

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  start a new iteration: zero all records and `overflow`.
- `in_valid`  in  1  point/index pair valid.
- `in_ready`  out  1  block can accept a point.
- `in_point`  in  `center_size`  point, packed `{z, y, x}`.
- `in_idx`  in  `idx_size`  winning cluster index.
- `rd_en`  in  1  read request.
- `rd_idx`  in  `idx_size`  record to read.
- `rd_valid`  out  1  `rd_data` valid.
- `rd_data`  out  `data_size`  record, `{counter, accZ, accY, accX}` in the low bits, upper bits zero.
- `busy`  out  1  clear sweep or update in flight.
- `overflow`  out  1  sticky error flag.

## Operation
- State machine with two states:
  - READY: `in_ready = 1`.
  - CLEAR: `in_ready = 0`. Sweeps `j = 0..k-1`, zeroing record `j` on each edge. Returns to READY after record `k-1`.
- A handshake is `in_valid && in_ready` at an edge. It captures `in_point` and `in_idx` into stage register S1 and sets `s1_valid`.
- Update: on the edge after capture, with `s1_valid = 1`, record `in_idx` is rewritten.
  - Each of `accX`, `accY`, `accZ` gets `acc + coordinate`, zero-extended to `acc_size+1` bits. If the sum exceeds `2^acc_size - 1`, the field saturates to all-ones and `overflow` sets.
  - `counter` gets `counter + 1`.
- Rejected points:
  - If `counter == max_n`, the whole point is dropped, the record is unchanged and `overflow` sets.
  - If `in_idx >= k`, the point is dropped and `overflow` sets.
- Throughput is one point per cycle. Back-to-back points to the same index accumulate correctly because each write completes before the next S1 read.
- Read:
  - `rd_en` sampled at an edge loads `rd_data` with record `rd_idx` and sets `rd_valid` for one cycle.
  - If the S1 write to the same record commits at that same edge, `rd_data` returns the post-write value (bypass).
  - `rd_en` during CLEAR returns zero for records already swept and the old value otherwise.
  - `rd_idx >= k` returns zero with `rd_valid = 1`.
- `clear` sampled high:
  - Enters CLEAR with sweep index 0, whatever the current state. Asserting it again during CLEAR restarts the sweep.
  - Clears `overflow`.
  - Discards any pending S1 update.
  - A handshake coinciding with `clear` is consumed but discarded.
- `busy = (state == CLEAR) || s1_valid`.

## Timing
- Reset values:
  - state READY, so `in_ready = 1`.
  - all records zero.
  - `s1_valid = 0`, `rd_valid = 0`, `rd_data = 0`, `overflow = 0`, `busy = 0`.
- Update latency: a handshake at edge E writes the record at edge E+1. A read sampled at E+1 already sees it through the bypass.
- Read latency: 1 cycle from `rd_en` to `rd_valid` and `rd_data`.
- Clear: `clear` sampled at edge C gives `in_ready = 0` from C until `in_ready = 1` after edge C+k. Record `j` is zero after edge C+j+1.
- Reset asserted mid-operation immediately forces all reset values, including an aborted sweep and a dropped S1 update.
- `overflow` sets at the edge where the dropped or saturated update would commit. It holds until `clear` or reset.

## Test plan
- Reset check: after reset, read indices 0..3 → each returns `rd_data = 0` with `rd_valid` one cycle after `rd_en`; also `in_ready = 1` and `overflow = 0`.
- Back-to-back accumulation: send points (10,20,30)→idx1 and (1,2,3)→idx1 on consecutive cycles, then read idx1 in the cycle after the second write → counter 2, acc (11,22,33); idx0, idx2 and idx3 remain 0.
- Counter limit: send 101 points of (1,1,1) to idx0 → counter 100, acc (100,100,100), `overflow = 1` set at the 101st write edge.
- Accumulator saturation (`acc_size = 10`): send 5 points of (255,0,0) to idx2 → after 4 points accX = 1020 and `overflow = 0`; after the 5th, accX = 1023, counter 5, `overflow = 1`.
- Clear collides with traffic: stream to idx3, then assert `clear` together with a handshake → that point is discarded, `in_ready = 0` for 4 cycles, then all records read 0 and `overflow = 0`.
- Bad index and mid-op reset (`k = 3`): send idx 3 → no record changes, `overflow = 1`. Then pull `rst` low during a CLEAR sweep → all outputs immediately take reset values, and after release `in_ready = 1`.

Source files
------------

// File: rtl/cluster_acc_update_if.sv
// rtl/cluster_acc_update_if.sv - point, read and status bundle for cluster_acc_update
interface cluster_acc_update_if #(
  parameter int center_size = 24,
  parameter int idx_size    = 2,
  parameter int data_size   = 61
);
  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [center_size-1:0] in_point;
  logic [idx_size-1:0]    in_idx;
  logic                   rd_en;
  logic [idx_size-1:0]    rd_idx;
  logic                   rd_valid;
  logic [data_size-1:0]   rd_data;
  logic                   busy;
  logic                   overflow;

  modport master (
    output clear, in_valid, in_point, in_idx, rd_en, rd_idx,
    input  in_ready, rd_valid, rd_data, busy, overflow
  );

  modport slave (
    input  clear, in_valid, in_point, in_idx, rd_en, rd_idx,
    output in_ready, rd_valid, rd_data, busy, overflow
  );
endinterface

// File: rtl/cluster_acc_update.sv
// rtl/cluster_acc_update.sv - per-cluster accumulator/counter update stage for k-means
// Records are packed {counter, accZ, accY, accX} so tree nodes load straight from rd_data.
module cluster_acc_update #(
  parameter int dim        = 3,
  parameter int data_range = 255,
  parameter int k          = 4,
  parameter int max_n      = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  cluster_acc_update_if.slave  bus
);
  localparam int dim_size     = $clog2(data_range);
  localparam int center_size  = dim * dim_size;
  localparam int counter_size = $clog2(max_n);
  localparam int acc_size     = $clog2(dim_size * max_n);
  localparam int data_size    = center_size + counter_size + 3 * acc_size;
  localparam int idx_size     = (k > 1) ? $clog2(k) : 1;
  localparam int rec_size     = counter_size + 3 * acc_size;

  localparam logic [counter_size-1:0] MAX_CNT = counter_size'(max_n);
  localparam logic [counter_size-1:0] CNT_ONE = counter_size'(1);
  localparam logic [idx_size-1:0]     K_LAST  = idx_size'(k - 1);

  typedef enum logic {ST_READY, ST_CLEAR} state_t;

  state_t                  state_q, state_d;
  logic [idx_size-1:0]     sweep_q, sweep_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [center_size-1:0]  s1_point_q, s1_point_d;
  logic [idx_size-1:0]     s1_idx_q, s1_idx_d;
  logic [rec_size-1:0]     mem_q [k];
  logic [rec_size-1:0]     mem_d [k];
  logic                    rd_valid_q, rd_valid_d;
  logic [data_size-1:0]    rd_data_q, rd_data_d;
  logic                    overflow_q, overflow_d;

  logic [rec_size-1:0]     cur_rec;
  logic [rec_size-1:0]     new_rec;
  logic [acc_size:0]       sum;
  logic                    sat;
  logic                    idx_ok;
  logic                    cnt_full;
  logic                    upd_go;
  logic                    wr_ok;
  logic                    err;
  logic                    handshake;

  assign handshake = bus.in_valid && (state_q == ST_READY);
  assign idx_ok    = int'(s1_idx_q) < k;

  always_comb begin
    cur_rec = '0;
    for (int j = 0; j < k; j++) begin
      if (s1_idx_q == idx_size'(j)) cur_rec = mem_q[j];
    end
  end

  // Each axis sum carries one spare bit so saturation is a simple carry test.
  always_comb begin
    new_rec = cur_rec;
    sat     = 1'b0;
    sum     = '0;
    for (int a = 0; a < 3; a++) begin
      sum = {1'b0, cur_rec[a*acc_size +: acc_size]}
          + (acc_size+1)'(s1_point_q[a*dim_size +: dim_size]);
      if (sum[acc_size]) begin
        new_rec[a*acc_size +: acc_size] = '1;
        sat = 1'b1;
      end else begin
        new_rec[a*acc_size +: acc_size] = sum[acc_size-1:0];
      end
    end
    new_rec[rec_size-1 -: counter_size] = cur_rec[rec_size-1 -: counter_size] + CNT_ONE;
  end

  assign cnt_full = (cur_rec[rec_size-1 -: counter_size] == MAX_CNT);
  assign upd_go   = s1_valid_q && !bus.clear;
  assign wr_ok    = upd_go && idx_ok && !cnt_full;
  assign err      = upd_go && (!idx_ok || cnt_full || sat);

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    s1_valid_d = 1'b0;
    s1_point_d = s1_point_q;
    s1_idx_d   = s1_idx_q;
    mem_d      = mem_q;
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q | err;

    for (int j = 0; j < k; j++) begin
      if (wr_ok && s1_idx_q == idx_size'(j)) mem_d[j] = new_rec;
    end

    // Reads bypass a write committing on the same edge; sweep zeroing is not bypassed.
    if (bus.rd_en) begin
      rd_data_d = '0;
      for (int j = 0; j < k; j++) begin
        if (bus.rd_idx == idx_size'(j)) begin
          rd_data_d[rec_size-1:0] = (wr_ok && s1_idx_q == idx_size'(j)) ? new_rec : mem_q[j];
        end
      end
    end

    case (state_q)
      ST_READY: begin
        if (handshake) begin
          s1_valid_d = 1'b1;
          s1_point_d = bus.in_point;
          s1_idx_d   = bus.in_idx;
        end
      end
      ST_CLEAR: begin
        for (int j = 0; j < k; j++) begin
          if (sweep_q == idx_size'(j)) mem_d[j] = '0;
        end
        if (sweep_q == K_LAST) state_d = ST_READY;
        else                   sweep_d = sweep_q + idx_size'(1);
      end
      default: state_d = ST_READY;
    endcase

    if (bus.clear) begin
      state_d    = ST_CLEAR;
      sweep_d    = '0;
      s1_valid_d = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_READY;
      sweep_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_point_q <= '0;
      s1_idx_q   <= '0;
      mem_q      <= '{default: '0};
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      s1_valid_q <= s1_valid_d;
      s1_point_q <= s1_point_d;
      s1_idx_q   <= s1_idx_d;
      mem_q      <= mem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready = (state_q == ST_READY);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = (state_q == ST_CLEAR) || s1_valid_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_cluster_acc_update.sv
// tb/tb_cluster_acc_update.sv - directed and random checks of cluster_acc_update against an arithmetic model
module tb_cluster_acc_update;
  localparam int K      = 4;
  localparam int MAXN   = 100;
  localparam int ACCMAX = 1023;

  logic clk;
  logic rst4;
  logic rst3;
  int   n_pass;
  int   n_fail;

  int m_cnt [K];
  int m_acc [K][3];
  bit m_ovf;

  cluster_acc_update_if #(.center_size(24), .idx_size(2), .data_size(61)) if4 ();
  cluster_acc_update_if #(.center_size(24), .idx_size(2), .data_size(61)) if3 ();

  cluster_acc_update #(.dim(3), .data_range(255), .k(4), .max_n(100)) u_dut (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  cluster_acc_update #(.dim(3), .data_range(255), .k(3), .max_n(100)) u_k3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < K; i++) begin
      m_cnt[i] = 0;
      for (int a = 0; a < 3; a++) m_acc[i][a] = 0;
    end
    m_ovf = 0;
  endtask

  task automatic model_add(input int idx, input int x, input int y, input int z);
    int c[3];
    c = '{x, y, z};
    if (idx >= K || m_cnt[idx] == MAXN) begin
      m_ovf = 1;
    end else begin
      for (int a = 0; a < 3; a++) begin
        m_acc[idx][a] += c[a];
        if (m_acc[idx][a] > ACCMAX) begin
          m_acc[idx][a] = ACCMAX;
          m_ovf = 1;
        end
      end
      m_cnt[idx]++;
    end
  endtask

  function automatic logic [63:0] exp_rec(input int idx);
    if (idx >= K) return 64'd0;
    return {27'd0, 7'(m_cnt[idx]), 10'(m_acc[idx][2]), 10'(m_acc[idx][1]), 10'(m_acc[idx][0])};
  endfunction

  task automatic send(input int idx, input int x, input int y, input int z);
    if4.in_valid = 1'b1;
    if4.in_idx   = 2'(idx);
    if4.in_point = {8'(z), 8'(y), 8'(x)};
    model_add(idx, x, y, z);
    step();
    if4.in_valid = 1'b0;
  endtask

  task automatic read_chk(input int idx, input string tag);
    if4.rd_en  = 1'b1;
    if4.rd_idx = 2'(idx);
    step();
    if4.rd_en  = 1'b0;
    chk({tag, "_valid"}, 64'(if4.rd_valid), 64'd1);
    chk({tag, "_data"}, 64'(if4.rd_data), exp_rec(idx));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !if4.in_ready; i++) step();
    chk("ready_timeout", 64'(if4.in_ready), 64'd1);
  endtask

  task automatic do_clear();
    if4.clear = 1'b1;
    step();
    if4.clear = 1'b0;
    model_clear();
    wait_ready();
  endtask

  initial begin
    int ri, rx, ry, rz;
    clk = 0; n_pass = 0; n_fail = 0;
    rst4 = 0; rst3 = 0;
    if4.clear = 0; if4.in_valid = 0; if4.in_point = '0; if4.in_idx = '0; if4.rd_en = 0; if4.rd_idx = '0;
    if3.clear = 0; if3.in_valid = 0; if3.in_point = '0; if3.in_idx = '0; if3.rd_en = 0; if3.rd_idx = '0;
    model_clear();
    repeat (3) step();
    @(negedge clk);
    rst4 = 1; rst3 = 1;
    step();

    chk("rst_in_ready", 64'(if4.in_ready), 64'd1);
    chk("rst_overflow", 64'(if4.overflow), 64'd0);
    chk("rst_busy", 64'(if4.busy), 64'd0);
    chk("rst_rd_valid", 64'(if4.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(if4.rd_data), 64'd0);
    for (int i = 0; i < K; i++) read_chk(i, "rst_read");
    chk("rst_rd_valid_drop", 64'(if4.rd_valid), 64'd1);
    step();
    chk("rd_valid_one_cycle", 64'(if4.rd_valid), 64'd0);

    send(1, 10, 20, 30);
    send(1, 1, 2, 3);
    chk("b2b_busy", 64'(if4.busy), 64'd1);
    read_chk(1, "b2b_idx1");
    chk("b2b_literal", 64'(if4.rd_data), {27'd0, 7'd2, 10'd33, 10'd22, 10'd11});
    read_chk(0, "b2b_idx0");
    read_chk(2, "b2b_idx2");
    read_chk(3, "b2b_idx3");

    for (int i = 0; i < MAXN; i++) send(0, 1, 1, 1);
    step();
    chk("cnt_limit_pre_ovf", 64'(if4.overflow), 64'd0);
    send(0, 1, 1, 1);
    step();
    chk("cnt_limit_ovf", 64'(if4.overflow), 64'd1);
    read_chk(0, "cnt_limit_idx0");
    chk("cnt_limit_literal", 64'(if4.rd_data), {27'd0, 7'd100, 10'd100, 10'd100, 10'd100});

    do_clear();
    chk("clear_ovf", 64'(if4.overflow), 64'd0);
    for (int i = 0; i < 4; i++) send(2, 255, 0, 0);
    step();
    read_chk(2, "sat4_idx2");
    chk("sat4_ovf", 64'(if4.overflow), 64'd0);
    send(2, 255, 0, 0);
    step();
    chk("sat5_ovf", 64'(if4.overflow), 64'd1);
    read_chk(2, "sat5_idx2");
    chk("sat5_literal", 64'(if4.rd_data), {27'd0, 7'd5, 10'd0, 10'd0, 10'd1023});

    for (int i = 0; i < 3; i++) send(3, 7 + i, 8, 9);
    if4.in_valid = 1'b1; if4.in_idx = 2'd3; if4.in_point = {8'd1, 8'd1, 8'd1};
    if4.clear = 1'b1;
    step();
    if4.clear = 1'b0; if4.in_valid = 1'b0;
    model_clear();
    for (int c = 0; c < 4; c++) begin
      chk("clr_in_ready_low", 64'(if4.in_ready), 64'd0);
      chk("clr_busy", 64'(if4.busy), 64'd1);
      step();
    end
    chk("clr_in_ready_back", 64'(if4.in_ready), 64'd1);
    chk("clr_ovf", 64'(if4.overflow), 64'd0);
    for (int i = 0; i < K; i++) read_chk(i, "clr_read");

    for (int i = 0; i < 40; i++) begin
      ri = int'($urandom_range(0, K - 1));
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(0, 255));
      rz = int'($urandom_range(0, 255));
      send(ri, rx, ry, rz);
      if (i % 8 == 7) read_chk(int'($urandom_range(0, K - 1)), "rnd_mid");
    end
    for (int i = 0; i < K; i++) read_chk(i, "rnd_end");
    chk("rnd_ovf", 64'(if4.overflow), 64'(m_ovf));

    if3.in_valid = 1'b1; if3.in_idx = 2'd3; if3.in_point = {8'd9, 8'd9, 8'd9};
    step();
    if3.in_valid = 1'b0;
    step();
    chk("k3_badidx_ovf", 64'(if3.overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if3.rd_en = 1'b1; if3.rd_idx = 2'(i);
      step();
      if3.rd_en = 1'b0;
      chk("k3_bad_rd_valid", 64'(if3.rd_valid), 64'd1);
      chk("k3_bad_rd_data", 64'(if3.rd_data), 64'd0);
    end
    if3.in_valid = 1'b1; if3.in_idx = 2'd1; if3.in_point = {8'd7, 8'd6, 8'd5};
    step();
    if3.in_valid = 1'b0;
    step();
    if3.clear = 1'b1; if3.rd_en = 1'b1; if3.rd_idx = 2'd1;
    step();
    if3.clear = 1'b0; if3.rd_en = 1'b0;
    chk("k3_clr_in_ready", 64'(if3.in_ready), 64'd0);
    chk("k3_clr_rd_valid", 64'(if3.rd_valid), 64'd1);
    chk("k3_clr_rd_data", 64'(if3.rd_data), {27'd0, 7'd1, 10'd7, 10'd6, 10'd5});
    chk("k3_clr_ovf", 64'(if3.overflow), 64'd0);
    step();
    rst3 = 1'b0;
    #1;
    chk("k3_rst_in_ready", 64'(if3.in_ready), 64'd1);
    chk("k3_rst_busy", 64'(if3.busy), 64'd0);
    chk("k3_rst_rd_valid", 64'(if3.rd_valid), 64'd0);
    chk("k3_rst_rd_data", 64'(if3.rd_data), 64'd0);
    chk("k3_rst_ovf", 64'(if3.overflow), 64'd0);
    @(negedge clk);
    rst3 = 1'b1;
    step();
    chk("k3_post_rst_ready", 64'(if3.in_ready), 64'd1);
    if3.rd_en = 1'b1; if3.rd_idx = 2'd1;
    step();
    if3.rd_en = 1'b0;
    chk("k3_post_rst_rd", 64'(if3.rd_data), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
